// File: rtl/iu_fetch_ctrl.sv
// rtl/iu_fetch_ctrl.sv - fetch/decode/execute sequencer driving the Instruction Unit control pins
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   ir_out     current IR contents from the Instruction Unit
//   ex_done    execute datapath completion pulse (only honoured in EXECUTE)
//   br_taken   branch condition, only honoured with ex_done on BEQ/BNE
//   pc_ld      load PC from the mux selected by pc_sel
//   pc_inc     advance PC by 4
//   ir_ld      capture instruction memory word into IR
//   im_cs      instruction memory chip select
//   im_rd      instruction memory read strobe
//   im_wr      instruction memory write strobe (always 0)
//   pc_sel     PC mux select: 00 PC_in, 01 jump target, 10 branch target
//   ex_start   one-cycle start pulse to the execute datapath
//   halted     core stopped (BREAK or watchdog)
//   wd_err     halt was caused by the execute watchdog
//   instr_cnt  number of instruction fetches since reset (wraps)

module iu_fetch_ctrl #(
    parameter int CNT_W = 16,
    parameter int WD_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ir_out,
    input  logic             ex_done,
    input  logic             br_taken,
    output logic             pc_ld,
    output logic             pc_inc,
    output logic             ir_ld,
    output logic             im_cs,
    output logic             im_rd,
    output logic             im_wr,
    output logic [1:0]       pc_sel,
    output logic             ex_start,
    output logic             halted,
    output logic             wd_err,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_BREAK   = 6'h0D;

    localparam logic [1:0] SEL_PC_IN  = 2'b00;
    localparam logic [1:0] SEL_JUMP   = 2'b01;
    localparam logic [1:0] SEL_BRANCH = 2'b10;

    localparam logic [WD_W-1:0]  WD_MAX  = {WD_W{1'b1}};
    localparam logic [WD_W-1:0]  WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t          state;
    state_t          state_nxt;
    logic [WD_W-1:0] wd_cnt;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_j;
    logic       is_jal;
    logic       is_jr;
    logic       is_break;
    logic       is_branch;
    logic       unused_ir;

    assign opcode    = ir_out[31:26];
    assign funct     = ir_out[5:0];
    assign unused_ir = ^ir_out[25:6];

    assign is_j      = (opcode == OP_J);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jr     = (opcode == OP_SPECIAL) && (funct == FN_JR);
    assign is_break  = (opcode == OP_SPECIAL) && (funct == FN_BREAK);
    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);

    // The watchdog only trips when execute is still outstanding; a completion
    // arriving on the same cycle the count hits its limit takes priority.
    logic wd_trip;
    assign wd_trip = (state == ST_EXECUTE) && !ex_done && (wd_cnt == WD_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            instr_cnt <= '0;
            wd_cnt    <= '0;
            wd_err    <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == ST_FETCH) begin
                instr_cnt <= instr_cnt + CNT_ONE;
            end

            if (state == ST_DECODE) begin
                wd_cnt <= '0;
            end else if ((state == ST_EXECUTE) && !ex_done && (wd_cnt != WD_MAX)) begin
                wd_cnt <= wd_cnt + WD_ONE;
            end

            if (wd_trip) begin
                wd_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pc_ld     = 1'b0;
        pc_inc    = 1'b0;
        ir_ld     = 1'b0;
        im_cs     = 1'b0;
        im_rd     = 1'b0;
        im_wr     = 1'b0;
        pc_sel    = SEL_PC_IN;
        ex_start  = 1'b0;
        halted    = 1'b0;

        case (state)
            ST_IDLE: begin
                state_nxt = ST_FETCH;
            end

            ST_FETCH: begin
                im_cs     = 1'b1;
                im_rd     = 1'b1;
                ir_ld     = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = ST_DECODE;
            end

            ST_DECODE: begin
                if (is_j) begin
                    pc_sel    = SEL_JUMP;
                    pc_ld     = 1'b1;
                    state_nxt = ST_FETCH;
                end else if (is_break) begin
                    state_nxt = ST_HALT;
                end else begin
                    ex_start  = 1'b1;
                    state_nxt = ST_EXECUTE;
                end
            end

            ST_EXECUTE: begin
                if (ex_done) begin
                    state_nxt = ST_FETCH;
                    if (is_branch && br_taken) begin
                        pc_sel = SEL_BRANCH;
                        pc_ld  = 1'b1;
                    end else if (is_jal) begin
                        pc_sel = SEL_JUMP;
                        pc_ld  = 1'b1;
                    end else if (is_jr) begin
                        // rs value is presented on PC_in by the datapath
                        pc_sel = SEL_PC_IN;
                        pc_ld  = 1'b1;
                    end
                end else if (wd_trip) begin
                    state_nxt = ST_HALT;
                end
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
